// File: rtl/compare_event_monitor_pkg.sv
// rtl/compare_event_monitor_pkg.sv - shared state encoding, run width and flag helper
package compare_event_monitor_pkg;

  localparam int RUN_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    ALARM  = 2'd2,
    DISARM = 2'd3
  } state_e;

  // A comparator sample is only meaningful when exactly one of gt/eq/lt is set.
  function automatic logic is_one_hot(input logic a, input logic b, input logic c);
    return ({1'b0, a} + {1'b0, b} + {1'b0, c}) == 2'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // clr beats inc, so an increment in the clearing cycle is dropped.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/compare_event_monitor.sv
// rtl/compare_event_monitor.sv - debounced gt/lt alarm with event count and illegal-flag detect
module compare_event_monitor
  import compare_event_monitor_pkg::*;
#(
  parameter int HOLD  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  input  logic             clr,
  output logic             alarm,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] event_cnt,
  output logic             err
);

  localparam logic [RUN_W-1:0] HOLD_V = RUN_W'(HOLD);

  state_e            state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [RUN_W-1:0]  run_inc;
  logic              alarm_q, alarm_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              err_q, err_d;
  logic              enter_alarm;
  logic              legal;

  assign legal   = is_one_hot(x, y, z);
  assign run_inc = run_q + RUN_W'(1);

  // run is always 0 in IDLE and ALARM, so run_inc is 1 there and HOLD==1 falls out naturally.
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    alarm_d     = alarm_q;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    err_d       = err_q;
    enter_alarm = 1'b0;
    if (valid && !legal) begin
      err_d = 1'b1;
    end else if (valid) begin
      unique case (state_q)
        IDLE, ARM: begin
          if (x) begin
            if (run_inc == HOLD_V) begin
              state_d     = ALARM;
              run_d       = '0;
              alarm_d     = 1'b1;
              rise_d      = 1'b1;
              enter_alarm = 1'b1;
            end else begin
              state_d = ARM;
              run_d   = run_inc;
            end
          end else begin
            state_d = IDLE;
            run_d   = '0;
          end
        end
        ALARM, DISARM: begin
          if (z) begin
            if (run_inc == HOLD_V) begin
              state_d = IDLE;
              run_d   = '0;
              alarm_d = 1'b0;
              fall_d  = 1'b1;
            end else begin
              state_d = DISARM;
              run_d   = run_inc;
            end
          end else if (x) begin
            state_d = ALARM;
            run_d   = '0;
          end
          // y while disarming holds state and run, biasing toward keeping the alarm.
        end
        default: begin
          state_d = IDLE;
          run_d   = '0;
        end
      endcase
    end
    if (clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      run_q   <= '0;
      alarm_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      alarm_q <= alarm_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_event_cnt (
    .clk_i   (clk),
    .reset_i (reset),
    .inc_i   (enter_alarm),
    .clr_i   (clr),
    .count_o (event_cnt)
  );

  assign alarm = alarm_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign err   = err_q;

endmodule
